// File: rtl/fmc_i2c_pkg.sv
// Shared types and constants for the FMC CPLD command sequencer: FSM state
// encoding, command table entry layout, CPLD register map and default table.
package fmc_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_BACKOFF  = 3'd3,
    ST_FINISH   = 3'd4
  } seq_state_e;

  // One register write: target register and the byte written to it.
  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } cmd_entry_t;

  localparam logic [6:0] CLPD_ADDR     = 7'b0111110;
  localparam logic [7:0] CLPD_CTRL_REG = 8'h02;
  localparam logic [7:0] CLPD_LED4_ON  = 8'h01;

  localparam int DEF_TABLE_LEN = 4;

  // Power-up write list, index 0 is written first. Listed here from index 3
  // down to index 0 because this is a packed concatenation.
  localparam cmd_entry_t [DEF_TABLE_LEN-1:0] DEF_TABLE = {
    {CLPD_CTRL_REG, CLPD_LED4_ON},
    {8'h04,         8'h00},
    {8'h03,         8'h00},
    {CLPD_CTRL_REG, CLPD_LED4_ON}
  };

  // Counter/index width that stays at least one bit for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fmc_cpld_cmd_rom.sv
// Combinational lookup of the register-write table. Indices beyond the
// default table (only possible with NUM_CMDS > DEF_TABLE_LEN) read as zero.
module fmc_cpld_cmd_rom
  import fmc_i2c_pkg::*;
#(
  parameter int NUM_CMDS = 4,
  parameter int IDX_W    = 2
) (
  input  logic [IDX_W-1:0] idx_i,
  output cmd_entry_t       entry_o
);

  // Decode the index against the package table.
  always_comb begin
    entry_o = '0;
    for (int i = 0; i < DEF_TABLE_LEN; i++) begin
      if ((i < NUM_CMDS) && (idx_i == IDX_W'(i))) begin
        entry_o = DEF_TABLE[i];
      end
    end
  end

endmodule

// File: rtl/fmc_cpld_cmd_sequencer.sv
// Walks the CPLD register-write table over an I2C command/response
// handshake, retrying NACKed entries after a fixed backoff and flagging the
// first entry that runs out of retries.
module fmc_cpld_cmd_sequencer
  import fmc_i2c_pkg::*;
#(
  parameter int         NUM_CMDS    = 4,
  parameter int         MAX_RETRY   = 3,
  parameter int         BACKOFF_CYC = 1000,
  parameter logic [6:0] DEV_ADDR    = CLPD_ADDR,
  localparam int        IDX_W       = idx_width(NUM_CMDS)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_idx,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [6:0]       cmd_dev_addr,
  output logic [7:0]       cmd_reg,
  output logic [7:0]       cmd_data,
  input  logic             rsp_valid,
  input  logic             rsp_nack
);

  localparam int RETRY_W = idx_width(MAX_RETRY + 1);
  localparam int BO_W    = idx_width(BACKOFF_CYC);

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_CMDS - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  // Counter runs load..0 inclusive, so BACKOFF_CYC cycles are spent waiting.
  localparam logic [BO_W-1:0]    BO_LOAD   = BO_W'((BACKOFF_CYC > 0) ? BACKOFF_CYC - 1 : 0);

  seq_state_e         state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_d;
  logic [RETRY_W-1:0] retry_q;
  logic [BO_W-1:0]    backoff_q;
  logic               busy_q;
  logic               done_q;
  logic               error_q;
  logic [IDX_W-1:0]   err_idx_q;
  logic               cmd_valid_q;
  logic [6:0]         cmd_dev_addr_q;
  logic [7:0]         cmd_reg_q;
  logic [7:0]         cmd_data_q;
  cmd_entry_t         rom_entry;

  // Next table index; the ROM is addressed with it so the payload register
  // can be loaded on the same edge that enters ISSUE.
  always_comb begin
    idx_d = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) idx_d = '0;
      end
      ST_WAIT_RSP: begin
        if (rsp_valid && !rsp_nack && (idx_q != LAST_IDX)) idx_d = idx_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  fmc_cpld_cmd_rom #(
    .NUM_CMDS (NUM_CMDS),
    .IDX_W    (IDX_W)
  ) u_rom (
    .idx_i   (idx_d),
    .entry_o (rom_entry)
  );

  // Sequencer FSM with all outputs registered.
  //   IDLE     | waiting for start, outputs quiet
  //   ISSUE    | cmd_valid high, payload held until cmd_ready
  //   WAIT_RSP | waiting for the controller's ACK/NACK
  //   BACKOFF  | fixed wait after a NACK before reissuing the same entry
  //   FINISH   | one-cycle done pulse, busy drops next cycle
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      retry_q        <= '0;
      backoff_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      err_idx_q      <= '0;
      cmd_valid_q    <= 1'b0;
      cmd_dev_addr_q <= '0;
      cmd_reg_q      <= '0;
      cmd_data_q     <= '0;
    end else begin
      idx_q  <= idx_d;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q        <= ST_ISSUE;
            retry_q        <= '0;
            backoff_q      <= '0;
            busy_q         <= 1'b1;
            error_q        <= 1'b0;
            err_idx_q      <= '0;
            cmd_valid_q    <= 1'b1;
            cmd_dev_addr_q <= DEV_ADDR;
            cmd_reg_q      <= rom_entry.reg_addr;
            cmd_data_q     <= rom_entry.data;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (rsp_valid) begin
            if (!rsp_nack) begin
              if (idx_q == LAST_IDX) begin
                state_q <= ST_FINISH;
                done_q  <= 1'b1;
              end else begin
                retry_q        <= '0;
                state_q        <= ST_ISSUE;
                cmd_valid_q    <= 1'b1;
                cmd_dev_addr_q <= DEV_ADDR;
                cmd_reg_q      <= rom_entry.reg_addr;
                cmd_data_q     <= rom_entry.data;
              end
            end else if (retry_q < RETRY_MAX) begin
              retry_q   <= retry_q + RETRY_W'(1);
              backoff_q <= BO_LOAD;
              state_q   <= ST_BACKOFF;
            end else begin
              error_q   <= 1'b1;
              err_idx_q <= idx_q;
              state_q   <= ST_FINISH;
              done_q    <= 1'b1;
            end
          end
        end
        ST_BACKOFF: begin
          if (backoff_q == '0) begin
            state_q        <= ST_ISSUE;
            cmd_valid_q    <= 1'b1;
            cmd_dev_addr_q <= DEV_ADDR;
            cmd_reg_q      <= rom_entry.reg_addr;
            cmd_data_q     <= rom_entry.data;
          end else begin
            backoff_q <= backoff_q - BO_W'(1);
          end
        end
        ST_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_idx      = err_idx_q;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_dev_addr = cmd_dev_addr_q;
  assign cmd_reg      = cmd_reg_q;
  assign cmd_data     = cmd_data_q;

endmodule

// File: doc/fmc_cpld_cmd_sequencer.md
FMC_CPLD_CMD_SEQUENCER -- requirements
Module: fmc_cpld_cmd_sequencer

Interface
REQ-001 SHALL have parameter NUM_CMDS, default 4: entries in the register-write table.
REQ-002 SHALL have parameter MAX_RETRY, default 3: retries per entry after a NACK.
REQ-003 SHALL have parameter BACKOFF_CYC, default 1000: CLK cycles waited after a NACK before retrying.
REQ-004 SHALL have parameter DEV_ADDR, default 7'b0111110: 7-bit CPLD I2C address.
REQ-005 SHALL have port CLK  in  1: sole clock, rising edge.
REQ-006 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-007 SHALL have port start  in  1: one-cycle request to run the table.
REQ-008 SHALL have port busy  out  1: high while a sequence runs.
REQ-009 SHALL have port done  out  1: one-cycle pulse at sequence end (success or error).
REQ-010 SHALL have port error  out  1: sticky; set when an entry exhausts its retries; cleared on accepted start.
REQ-011 SHALL have port err_idx  out  $clog2(NUM_CMDS): index of the failing entry, valid while error=1.
REQ-012 SHALL have port cmd_valid  out  1: write command to the I2C controller is valid.
REQ-013 SHALL have port cmd_ready  in  1: the controller accepts the command.
REQ-014 SHALL have ports cmd_dev_addr  out  7, cmd_reg  out  8, cmd_data  out  8: command payload.
REQ-015 SHALL have ports rsp_valid  in  1 and rsp_nack  in  1: transaction complete; nack=1 means any byte was NACKed.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT_RSP, BACKOFF, FINISH.
REQ-017 IDLE: start=1 -> ISSUE; idx=0, retry=0, error cleared; busy=1 from the next cycle.
REQ-018 ISSUE: cmd_valid=1, payload = DEV_ADDR, table[idx].reg, table[idx].data, held stable until cmd_valid&&cmd_ready; on that cycle -> WAIT_RSP.
REQ-019 WAIT_RSP: cmd_valid=0; sample rsp_valid only here, from the cycle after the handshake.
REQ-020 rsp_valid&&!rsp_nack: idx==NUM_CMDS-1 -> FINISH, else idx+1, retry=0 -> ISSUE.
REQ-021 rsp_valid&&rsp_nack: retry<MAX_RETRY -> retry+1, load backoff=BACKOFF_CYC-1 -> BACKOFF; retry==MAX_RETRY -> error=1, err_idx=idx -> FINISH.
REQ-022 BACKOFF: decrement each cycle; at 0 -> ISSUE with the same idx. Total BACKOFF_CYC cycles spent in BACKOFF.
REQ-023 FINISH: done=1 for exactly one cycle, busy=0 from the next cycle -> IDLE.
REQ-024 A failing entry SHALL be issued exactly MAX_RETRY+1 times; remaining entries are skipped.
REQ-025 start while busy SHALL be ignored; start on the FINISH cycle is ignored.
REQ-026 rsp_valid outside WAIT_RSP SHALL be ignored.
REQ-027 cmd_ready while cmd_valid=0 SHALL have no effect.
REQ-028 The retry and backoff counters SHALL saturate, never wrap. idx SHALL never exceed NUM_CMDS-1.
REQ-029 Default table: {0x02,0x01} (control reg, LED4 on), {0x03,0x00}, {0x04,0x00}, {0x02,0x01}.

Reset
REQ-030 Asserting reset, including mid-transaction, SHALL force IDLE: busy=0, done=0, error=0, err_idx=0, cmd_valid=0, payload=0, counters 0.
REQ-031 After reset deassertion the block SHALL remain IDLE until start; a pending controller response is ignored.

Structure
REQ-032 Package fmc_i2c_pkg SHALL hold: the state enum, cmd entry struct {reg, data}, CLPD_ADDR=7'b0111110, CLPD_CTRL_REG=8'h02, CLPD_LED4_ON=8'h01, and the default table.
REQ-033 One sub-module, fmc_cpld_cmd_rom, SHALL provide table[idx] combinationally from the package constants.
REQ-034 All outputs SHALL be registered.

Verification
REQ-035 start, cmd_ready=1, rsp ACK 2 cycles after each handshake -> 4 handshakes, payloads 3E/02/01, 3E/03/00, 3E/04/00, 3E/02/01 in order; done pulse once; error=0.
REQ-036 Entry 1 NACKed once, then ACK -> entry 1 issued twice; cycles between the NACK and the re-issue cmd_valid = BACKOFF_CYC+1; done with error=0.
REQ-037 Entry 2 always NACKed -> entry 2 issued 4 times; entry 3 never issued; error=1, err_idx=2, done pulse; next start clears error.
REQ-038 cmd_ready held low 50 cycles -> cmd_valid and payload stable for all 50 cycles; no idx advance.
REQ-039 Reset asserted in WAIT_RSP and in BACKOFF -> all outputs at reset values asynchronously; a stray rsp_valid after release gives no state change.
REQ-040 start pulsed while busy, and rsp_valid pulsed in ISSUE -> no effect on sequence order or counts.
